time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1_000_000, clk cycles a raw button must hold a new level before acceptance.
REQ-002 SHALL provide parameter TIMEOUT_TICKS, default 30, tick rising edges without a button event before a set mode exits.
REQ-003 SHALL provide parameter REPEAT_TICKS, default 2, tick rising edges btn_up must be held before auto-repeat starts (REQ-030).
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_mode  input  1  raw asynchronous mode button, high = pressed.
REQ-007 btn_up  input  1  raw asynchronous increment button, high = pressed.
REQ-008 tick_one_Hz  input  1  1 Hz square wave from the timekeeper; its rising edge is the timekeeper's update instant.
REQ-009 hours_inc  output  1  hour increment request level to the timekeeper.
REQ-010 mins_inc  output  1  minute increment request level to the timekeeper.
REQ-011 am_or_pm  output  1  AM/PM toggle request level to the timekeeper.
REQ-012 mode  output  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_AMPM.
REQ-013 blink_hour, blink_min, blink_ampm  output  1 each  display blank enables for the edited field.
REQ-014 req_busy  output  1  an increment request is pending.

Function
REQ-015 btn_mode, btn_up, tick_one_Hz SHALL each pass a 2-flop synchronizer before any use.
REQ-016 Debounced level SHALL change only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive clk cycles; any mismatch gap restarts the count.
REQ-017 Press event SHALL be a one-cycle pulse on the debounced 0->1 transition; releases generate no event.
REQ-018 Tick edge SHALL be a one-cycle pulse on the synchronized tick 0->1 transition.
REQ-019 FSM SHALL advance on mode press: RUN->SET_HOUR->SET_MIN->SET_AMPM->RUN; mode output registered, valid the cycle after the press pulse.
REQ-020 Up press in RUN SHALL be ignored.
REQ-021 Up press in SET_x with no pending request SHALL latch target x, set req_busy, and raise the matching request output the next cycle.
REQ-022 Request output SHALL stay high until the first tick edge pulse at least one clk cycle after assertion, then drop in the following cycle together with req_busy; exactly one timekeeper edge is spanned.
REQ-023 Up presses while req_busy SHALL be discarded (one-deep, no queue).
REQ-024 Mode press while req_busy SHALL advance the FSM; the pending request SHALL complete on its latched target.
REQ-025 At most one request output SHALL be high in any cycle.
REQ-026 Idle counter SHALL clear on every press event and mode change, increment on tick edges in SET modes, and on reaching TIMEOUT_TICKS force mode to RUN (pending request still completes).
REQ-027 blink_x SHALL equal (mode==SET_x) AND synchronized tick level; all blink outputs 0 in RUN.
REQ-028 Mode press and up press in the same cycle: up acts on the pre-advance mode, then mode advances.

Reset
REQ-029 reset SHALL asynchronously force: mode 0, all request outputs 0, req_busy 0, blinks 0, debounced levels 0, debounce/idle/repeat counters 0, synchronizers 0; reset mid-request SHALL abandon it with no output glitch high.

Configuration
REQ-030 Macro TIME_SET_AUTOREPEAT_EN defined: with btn_up debounced high in a SET mode for REPEAT_TICKS tick edges, an increment request SHALL be issued on each subsequent tick edge while held and not busy; repeat count clears on release or mode change. Undefined: one request per press only; repeat logic absent.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_TICKS=3, REPEAT_TICKS=2, tick period 40 clk)
REQ-031 Bounce btn_mode 1/0 every 2 cycles for 20 cycles then hold high 10 -> exactly one mode step, 0->1.
REQ-032 Mode=SET_MIN, press up -> mins_inc high from cycle after press until cycle after next tick edge; hours_inc, am_or_pm stay 0; req_busy matches.
REQ-033 Mode=SET_HOUR, second up press while req_busy -> only one hours_inc assertion observed.
REQ-034 Mode=SET_AMPM, no presses for 3 tick edges -> mode returns 0, blinks 0.
REQ-035 Assert reset while hours_inc high -> hours_inc 0 immediately, mode 0, no request after release.
REQ-036 With TIME_SET_AUTOREPEAT_EN, hold up in SET_MIN for 6 tick edges -> 4 mins_inc pulses; without macro -> 1.

Source files
------------

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Desc     : Debounced mode/up buttons step a set-mode FSM and raise one-hot
//            increment requests, each held across exactly one tick edge.
//            Optional macro TIME_SET_AUTOREPEAT_EN enables hold-to-repeat on up.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_TICKS   = 30,
  parameter int REPEAT_TICKS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       tick_one_Hz,
  output logic       hours_inc,
  output logic       mins_inc,
  output logic       am_or_pm,
  output logic [1:0] mode,
  output logic       blink_hour,
  output logic       blink_min,
  output logic       blink_ampm,
  output logic       req_busy
);

  localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_AMPM = 2'd3
  } mode_t;

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("time_set_ctrl: DEBOUNCE_CYCLES, TIMEOUT_TICKS and REPEAT_TICKS must be >= 1");
  end

  // Bit order of the synchronizer vectors: {tick, up, mode}
  logic [2:0]          r_sync1;
  logic [2:0]          r_sync2;
  logic                r_tick_d;
  logic [1:0]          r_btn_db_d;
  logic [1:0]          w_btn_db;
  logic [1:0]          w_press;
  logic                w_mode_press;
  logic                w_up_press;
  logic                w_tick_edge;
  logic                w_in_set;
  logic                w_rpt_fire;
  logic                w_issue;
  logic                w_complete;
  mode_t               r_mode;
  logic                r_busy;
  logic                r_hours_inc;
  logic                r_mins_inc;
  logic                r_am_or_pm;
  logic [c_IDLE_W-1:0] r_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_tick_d   <= 1'b0;
      r_btn_db_d <= '0;
    end else begin
      r_sync1    <= {tick_one_Hz, btn_up, btn_mode};
      r_sync2    <= r_sync1;
      r_tick_d   <= r_sync2[2];
      r_btn_db_d <= w_btn_db;
    end
  end

  // Index 0 = mode button, 1 = up button
  for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
    logic [c_DB_W-1:0] r_cnt;
    logic              r_level;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (r_sync2[gi] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DB_LAST) begin
        r_level <= r_sync2[gi];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_btn_db[gi] = r_level;
  end

  assign w_press      = w_btn_db & ~r_btn_db_d;
  assign w_mode_press = w_press[0];
  assign w_up_press   = w_press[1];
  assign w_tick_edge  = r_sync2[2] & ~r_tick_d;
  assign w_in_set     = (r_mode != RUN);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int c_RPT_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [c_RPT_W-1:0] c_RPT_LAST = c_RPT_W'(REPEAT_TICKS - 1);

  logic [c_RPT_W-1:0] r_rpt;

  // Counts held tick edges; the REPEAT_TICKS-th held edge is the first to fire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rpt <= '0;
    end else if (!w_btn_db[1] || !w_in_set || w_mode_press) begin
      r_rpt <= '0;
    end else if (w_tick_edge && (r_rpt != c_RPT_LAST)) begin
      r_rpt <= r_rpt + 1'b1;
    end
  end

  assign w_rpt_fire = w_tick_edge & w_btn_db[1] & w_in_set & ~r_busy &
                      (r_rpt == c_RPT_LAST);
`else
  assign w_rpt_fire = 1'b0;
`endif

  // Up acts on the current (pre-advance) mode, so a same-cycle mode press is harmless
  assign w_issue    = w_in_set & ~r_busy & (w_up_press | w_rpt_fire);
  assign w_complete = r_busy & w_tick_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode      <= RUN;
      r_busy      <= 1'b0;
      r_hours_inc <= 1'b0;
      r_mins_inc  <= 1'b0;
      r_am_or_pm  <= 1'b0;
      r_idle      <= '0;
    end else begin
      if (w_issue) begin
        r_busy      <= 1'b1;
        r_hours_inc <= (r_mode == SET_HOUR);
        r_mins_inc  <= (r_mode == SET_MIN);
        r_am_or_pm  <= (r_mode == SET_AMPM);
      end else if (w_complete) begin
        r_busy      <= 1'b0;
        r_hours_inc <= 1'b0;
        r_mins_inc  <= 1'b0;
        r_am_or_pm  <= 1'b0;
      end

      // A repeat fire counts as user activity so a held button keeps the mode alive
      if (w_mode_press) begin
        r_mode <= mode_t'(r_mode + 2'd1);
        r_idle <= '0;
      end else if (w_up_press || w_rpt_fire) begin
        r_idle <= '0;
      end else if (w_in_set && w_tick_edge) begin
        if (r_idle == c_IDLE_LAST) begin
          r_mode <= RUN;
          r_idle <= '0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
    end
  end

  assign hours_inc  = r_hours_inc;
  assign mins_inc   = r_mins_inc;
  assign am_or_pm   = r_am_or_pm;
  assign req_busy   = r_busy;
  assign mode       = r_mode;
  assign blink_hour = (r_mode == SET_HOUR) & r_sync2[2];
  assign blink_min  = (r_mode == SET_MIN)  & r_sync2[2];
  assign blink_ampm = (r_mode == SET_AMPM) & r_sync2[2];

endmodule
`default_nettype wire
